// File: rtl/arb_req_ctrl_if.sv
// Command, request/grant and beat-report bundle between a burst source, arb_req_ctrl and the arbiter.
// The slave modport is the controller's view; the master modport is the source/arbiter side.
interface arb_req_ctrl_if #(
    parameter int LEN_W = 4
);
    logic             cmd_valid;
    logic [1:0]       cmd_id;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ready;

    logic             req_0;
    logic             req_1;
    logic             req_2;
    logic             req_3;
    logic             gnt_0;
    logic             gnt_1;
    logic             gnt_2;
    logic             gnt_3;

    logic             beat_valid;
    logic [1:0]       beat_id;
    logic             beat_last;
    logic [3:0]       done;
    logic             err_overrun;

    modport master (
        output cmd_valid, cmd_id, cmd_len,
        output gnt_0, gnt_1, gnt_2, gnt_3,
        input  cmd_ready,
        input  req_0, req_1, req_2, req_3,
        input  beat_valid, beat_id, beat_last, done, err_overrun
    );

    modport slave (
        input  cmd_valid, cmd_id, cmd_len,
        input  gnt_0, gnt_1, gnt_2, gnt_3,
        output cmd_ready,
        output req_0, req_1, req_2, req_3,
        output beat_valid, beat_id, beat_last, done, err_overrun
    );
endinterface

// File: rtl/arb_req_ctrl.sv
// Request-side front end for the 4-client grant arbiter: one burst per client, counted grants, enforced low gap.
// Optional arbiter over-grant checker enabled by defining ARB_REQ_OVERRUN_CHK_EN.
module arb_req_ctrl #(
    parameter int LEN_W = 4,
    parameter int GAP   = 2
) (
    input logic           clock,
    input logic           reset,
    arb_req_ctrl_if.slave bus
);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        C_IDLE,
        C_REQ,
        C_XFER,
        C_GAP
    } cstate_e;

    cstate_e          state_q [4];
    cstate_e          state_d [4];
    logic [LEN_W-1:0] len_q   [4];
    logic [LEN_W-1:0] len_d   [4];
    logic [LEN_W-1:0] cnt_q   [4];
    logic [LEN_W-1:0] cnt_d   [4];
    logic [GAP_W-1:0] gap_q   [4];
    logic [GAP_W-1:0] gap_d   [4];

    logic [3:0] gnt;
    logic [3:0] beat;
    logic [3:0] last;
    logic [3:0] req_q;
    logic [3:0] req_d;
    logic [3:0] done_q;
    logic [3:0] done_d;
    logic       beat_valid_q;
    logic       beat_valid_d;
    logic [1:0] beat_id_q;
    logic [1:0] beat_id_d;
    logic       beat_last_q;
    logic       beat_last_d;

    assign gnt           = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};
    assign bus.cmd_ready = (state_q[bus.cmd_id] == C_IDLE);

    // cnt is the index of the next beat, so the beat granted while cnt==len is the last one.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            len_d[n]   = len_q[n];
            cnt_d[n]   = cnt_q[n];
            gap_d[n]   = gap_q[n];
            beat[n]    = 1'b0;
            last[n]    = 1'b0;
            case (state_q[n])
                C_IDLE: begin
                    if (bus.cmd_valid && (bus.cmd_id == 2'(n))) begin
                        state_d[n] = C_REQ;
                        len_d[n]   = bus.cmd_len;
                        cnt_d[n]   = '0;
                    end
                end
                C_REQ, C_XFER: begin
                    if (gnt[n]) begin
                        beat[n] = 1'b1;
                        if (cnt_q[n] == len_q[n]) begin
                            last[n]    = 1'b1;
                            state_d[n] = C_GAP;
                            gap_d[n]   = GAP_W'(GAP - 1);
                        end else begin
                            cnt_d[n]   = cnt_q[n] + 1'b1;
                            state_d[n] = C_XFER;
                        end
                    end
                end
                C_GAP: begin
                    if (gap_q[n] != '0) begin
                        gap_d[n] = gap_q[n] - 1'b1;
                    end else if (!gnt[n]) begin
                        state_d[n] = C_IDLE;
                    end
                end
                default: state_d[n] = C_IDLE;
            endcase
            req_d[n] = (state_d[n] == C_REQ) || (state_d[n] == C_XFER);
        end
    end

    // Beat report picks the lowest-index client when several count a beat in the same cycle.
    always_comb begin
        beat_valid_d = |beat;
        beat_id_d    = 2'd0;
        beat_last_d  = 1'b0;
        done_d       = last;
        for (int n = 3; n >= 0; n--) begin
            if (beat[n]) begin
                beat_id_d   = 2'(n);
                beat_last_d = last[n];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= C_IDLE;
                len_q[n]   <= '0;
                cnt_q[n]   <= '0;
                gap_q[n]   <= '0;
            end
            req_q        <= '0;
            done_q       <= '0;
            beat_valid_q <= 1'b0;
            beat_id_q    <= 2'd0;
            beat_last_q  <= 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= state_d[n];
                len_q[n]   <= len_d[n];
                cnt_q[n]   <= cnt_d[n];
                gap_q[n]   <= gap_d[n];
            end
            req_q        <= req_d;
            done_q       <= done_d;
            beat_valid_q <= beat_valid_d;
            beat_id_q    <= beat_id_d;
            beat_last_q  <= beat_last_d;
        end
    end

    assign bus.req_0      = req_q[0];
    assign bus.req_1      = req_q[1];
    assign bus.req_2      = req_q[2];
    assign bus.req_3      = req_q[3];
    assign bus.beat_valid = beat_valid_q;
    assign bus.beat_id    = beat_id_q;
    assign bus.beat_last  = beat_last_q;
    assign bus.done       = done_q;

`ifdef ARB_REQ_OVERRUN_CHK_EN
    logic [1:0] age_q [4];
    logic [1:0] age_d [4];
    logic [3:0] overGrant;
    logic       err_q;
    logic       err_d;

    // age counts cycles spent in C_GAP (saturating); a grant beyond age 2 is the arbiter over-granting.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            if (state_q[n] != C_GAP) begin
                age_d[n] = 2'd0;
            end else if (age_q[n] == 2'd3) begin
                age_d[n] = 2'd3;
            end else begin
                age_d[n] = age_q[n] + 2'd1;
            end
            overGrant[n] = gnt[n] && ((state_q[n] == C_IDLE) ||
                                      ((state_q[n] == C_GAP) && (age_q[n] > 2'd2)));
        end
        err_d = err_q | (|overGrant) | ((gnt & (gnt - 4'd1)) != 4'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int n = 0; n < 4; n++) begin
                age_q[n] <= 2'd0;
            end
            err_q <= 1'b0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                age_q[n] <= age_d[n];
            end
            err_q <= err_d;
        end
    end

    assign bus.err_overrun = err_q;
`else
    assign bus.err_overrun = 1'b0;
`endif
endmodule

// File: tb/tb_arb_req_ctrl.sv
// Self-checking bench for arb_req_ctrl: directed scenarios plus a random phase against a beats-remaining model.
module tb_arb_req_ctrl;
    localparam int LEN_W = 4;
    localparam int GAP   = 2;

    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   beatsSeen;
    int   doneSeen;

    arb_req_ctrl_if #(.LEN_W(LEN_W)) bus ();

    arb_req_ctrl #(.LEN_W(LEN_W), .GAP(GAP)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: a client is either requesting with some beats remaining, cooling down after a burst, or idle.
    bit         mActive [4];
    bit         mCool   [4];
    int         mRem    [4];
    int         mSince  [4];
    logic [3:0] eReq;
    logic       eBeatValid;
    logic [1:0] eBeatId;
    logic       eBeatLast;
    logic [3:0] eDone;
    logic       eErr;
    logic       lastAccepted;

    task automatic modelReset();
        for (int n = 0; n < 4; n++) begin
            mActive[n] = 0;
            mCool[n]   = 0;
            mRem[n]    = 0;
            mSince[n]  = 0;
        end
        eReq = '0; eBeatValid = 0; eBeatId = 0; eBeatLast = 0; eDone = '0; eErr = 0;
    endtask

    function automatic bit modelIdle(input int n);
        return !mActive[n] && !mCool[n];
    endfunction

    task automatic modelStep(input logic v, input logic [1:0] id, input logic [3:0] len,
                             input logic [3:0] g);
        logic [3:0] beatNow;
        logic [3:0] lastNow;
        bit         accept;
        beatNow = '0;
        lastNow = '0;
        accept  = v && modelIdle(int'(id));
`ifdef ARB_REQ_OVERRUN_CHK_EN
        if ($countones(g) > 1) eErr = 1;
        for (int n = 0; n < 4; n++) begin
            if (g[n] && modelIdle(n)) eErr = 1;
            if (g[n] && mCool[n] && mSince[n] > 2) eErr = 1;
        end
`endif
        for (int n = 0; n < 4; n++) begin
            if (mActive[n]) begin
                if (g[n]) begin
                    beatNow[n] = 1;
                    mRem[n]    = mRem[n] - 1;
                    if (mRem[n] == 0) begin
                        lastNow[n] = 1;
                        mActive[n] = 0;
                        mCool[n]   = 1;
                        mSince[n]  = 0;
                    end
                end
            end else if (mCool[n]) begin
                if (mSince[n] >= GAP - 1 && !g[n]) mCool[n] = 0;
                else mSince[n] = mSince[n] + 1;
            end
        end
        if (accept) begin
            mActive[id] = 1;
            mRem[id]    = int'(len) + 1;
        end
        lastAccepted = accept;
        eDone      = lastNow;
        eBeatValid = |beatNow;
        eBeatId    = 0;
        eBeatLast  = 0;
        for (int n = 3; n >= 0; n--) begin
            if (beatNow[n]) begin
                eBeatId   = 2'(n);
                eBeatLast = lastNow[n];
            end
        end
        for (int n = 0; n < 4; n++) eReq[n] = mActive[n];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        chk("req", {28'd0, bus.req_3, bus.req_2, bus.req_1, bus.req_0}, {28'd0, eReq});
        chk("beat_valid", {31'd0, bus.beat_valid}, {31'd0, eBeatValid});
        if (eBeatValid) begin
            chk("beat_id", {30'd0, bus.beat_id}, {30'd0, eBeatId});
            chk("beat_last", {31'd0, bus.beat_last}, {31'd0, eBeatLast});
        end
        chk("done", {28'd0, bus.done}, {28'd0, eDone});
        chk("err_overrun", {31'd0, bus.err_overrun}, {31'd0, eErr});
        if (bus.beat_valid === 1'b1) beatsSeen++;
        doneSeen += $countones(bus.done);
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] id, input logic [3:0] len,
                                 input logic [3:0] g);
        bus.cmd_valid = v;
        bus.cmd_id    = id;
        bus.cmd_len   = len;
        {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0} = g;
        @(negedge clock);
        chk("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, logic'(modelIdle(int'(id)))});
        modelStep(v, id, len, g);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic doReset();
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_id    = 2'd0;
        bus.cmd_len   = '0;
        {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0} = 4'b0000;
        @(posedge clock);
        #1;
        reset = 1'b0;
        modelReset();
        checkOutput();
    endtask

    task automatic idleCycles(input int count);
        for (int i = 0; i < count; i++) applyStimulus(1'b0, 2'd0, 4'd0, 4'b0000);
    endtask

    logic       pendValid;
    logic [1:0] pendId;
    logic [3:0] pendLen;
    logic [3:0] rg;
    logic       expErr;

    initial begin
        total = 0; bad = 0; beatsSeen = 0; doneSeen = 0;
        reset = 1'b1;
        modelReset();
        doReset();

        // Client 2, four beats, grant two cycles after req and held through arbiter latency
        beatsSeen = 0; doneSeen = 0;
        applyStimulus(1'b1, 2'd2, 4'd3, 4'b0000);
        applyStimulus(1'b0, 2'd2, 4'd0, 4'b0000);
        applyStimulus(1'b0, 2'd2, 4'd0, 4'b0000);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'd2, 4'd0, 4'b0100);
        idleCycles(4);
        chk("burst4_beats", beatsSeen, 4);
        chk("burst4_done", doneSeen, 1);

        // Same burst with a two-cycle stall in the middle
        beatsSeen = 0; doneSeen = 0;
        applyStimulus(1'b1, 2'd2, 4'd3, 4'b0000);
        applyStimulus(1'b0, 2'd2, 4'd0, 4'b0000);
        applyStimulus(1'b0, 2'd2, 4'd0, 4'b0100);
        applyStimulus(1'b0, 2'd2, 4'd0, 4'b0100);
        applyStimulus(1'b0, 2'd2, 4'd0, 4'b0000);
        applyStimulus(1'b0, 2'd2, 4'd0, 4'b0000);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd2, 4'd0, 4'b0100);
        idleCycles(4);
        chk("stall_beats", beatsSeen, 4);

        // Single-beat burst on client 0 with grant held three extra cycles; re-request held by source
        beatsSeen = 0;
        applyStimulus(1'b1, 2'd0, 4'd0, 4'b0000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'd0, 4'd0, 4'b0001);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'd0, 4'd0, 4'b0000);
        chk("len0_beats", beatsSeen, 1);
        applyStimulus(1'b0, 2'd0, 4'd0, 4'b0001);
        idleCycles(4);

        // Clients 1 and 3 back to back; a further command to busy client 1 is held
        doneSeen = 0;
        applyStimulus(1'b1, 2'd1, 4'd2, 4'b0000);
        applyStimulus(1'b1, 2'd3, 4'd1, 4'b0000);
        chk("both_req", {28'd0, bus.req_3, bus.req_2, bus.req_1, bus.req_0}, 32'b1010);
        applyStimulus(1'b1, 2'd1, 4'd0, 4'b1010);
        applyStimulus(1'b1, 2'd1, 4'd0, 4'b1010);
        applyStimulus(1'b1, 2'd1, 4'd0, 4'b0010);
        applyStimulus(1'b1, 2'd1, 4'd0, 4'b0010);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd1, 4'd0, 4'b0000);
        applyStimulus(1'b0, 2'd1, 4'd0, 4'b0010);
        idleCycles(4);
        chk("pair_done", doneSeen, 3);

        // Reset during client 1 transfer after two of five beats
        doneSeen = 0;
        applyStimulus(1'b1, 2'd1, 4'd4, 4'b0000);
        applyStimulus(1'b0, 2'd1, 4'd0, 4'b0010);
        applyStimulus(1'b0, 2'd1, 4'd0, 4'b0010);
        doReset();
        applyStimulus(1'b0, 2'd1, 4'd0, 4'b0000);
        chk("rst_no_done", doneSeen, 0);
        chk("rst_req1", {31'd0, bus.req_1}, 32'd0);

        // Grant to idle client 0
`ifdef ARB_REQ_OVERRUN_CHK_EN
        expErr = 1'b1;
`else
        expErr = 1'b0;
`endif
        applyStimulus(1'b0, 2'd0, 4'd0, 4'b0001);
        chk("overrun_set", {31'd0, bus.err_overrun}, {31'd0, expErr});
        idleCycles(3);
        chk("overrun_hold", {31'd0, bus.err_overrun}, {31'd0, expErr});
        doReset();

        // Random phase: source holds each command until accepted, grants biased toward requesting clients
        pendValid = 1'b0; pendId = 2'd0; pendLen = 4'd0;
        for (int i = 0; i < 800; i++) begin
            if (!pendValid && ($urandom_range(0, 2) == 0)) begin
                pendValid = 1'b1;
                pendId    = 2'($urandom_range(0, 3));
                pendLen   = 4'($urandom_range(0, 6));
            end
            for (int n = 0; n < 4; n++) begin
                if (mActive[n]) rg[n] = ($urandom_range(0, 3) != 0);
                else rg[n] = ($urandom_range(0, 15) == 0);
            end
            applyStimulus(pendValid, pendId, pendLen, rg);
            if (lastAccepted) pendValid = 1'b0;
            if (i == 400) doReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
